// File: rtl/wb_regfile_sb_if.sv
// Bundle between issue/retire stages and the write-back register file.
// Read ports, destination reservation and the retire bus.
interface wb_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NRD  = 2
);
    logic [NRD*5-1:0]    rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    logic                iss_valid;
    logic                iss_wen;
    logic [4:0]          iss_rd;
    logic                iss_ready;
    logic                flush;

    logic                wb_valid;
    logic                wb_wen;
    logic [4:0]          wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                wb_pc_wen;
    logic [XLEN-1:0]     wb_pc_wdata;

    modport master (
        output rd_addr,
        input  rd_data,
        input  rd_busy,
        output iss_valid,
        output iss_wen,
        output iss_rd,
        input  iss_ready,
        output flush,
        output wb_valid,
        output wb_wen,
        output wb_rd,
        output wb_data,
        output wb_pc_wen,
        output wb_pc_wdata
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        output rd_busy,
        input  iss_valid,
        input  iss_wen,
        input  iss_rd,
        output iss_ready,
        input  flush,
        input  wb_valid,
        input  wb_wen,
        input  wb_rd,
        input  wb_data,
        input  wb_pc_wen,
        input  wb_pc_wdata
    );
endinterface

// File: rtl/wb_regfile_sb.sv
// Write-back stage: GPR file, scoreboard, retire bypass,
// retire-driven PC and 64-bit retired-instruction counter.
module wb_regfile_sb #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 16,
    parameter int              NRD      = 2,
    parameter bit              BYPASS   = 1'b1,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    wb_regfile_sb_if.slave       bus,
    output logic [XLEN-1:0]      pc,
    output logic [63:0]          instret,
    output logic [NREG-1:0]      pending,
    output logic                 sb_err,
    output logic [NREG*XLEN-1:0] dbg_gpr
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef logic [AW-1:0] idx_t;

    // Addresses outside the file and x0 never hold state.
    function automatic logic live(input logic [4:0] a);
        return (32'(a) < NREG) && (a != 5'd0);
    endfunction

    logic [XLEN-1:0] gpr [NREG];

    idx_t            wb_idx;
    logic            wb_live;
    logic            wb_wr;
    logic            wb_clr;

    idx_t            iss_idx;
    logic            iss_live;
    logic            iss_ok;
    logic            iss_set;

    logic [NREG-1:0] pend_nxt;

    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_busy_c;

    assign wb_idx  = bus.wb_rd[AW-1:0];
    assign wb_live = live(bus.wb_rd);
    assign wb_clr  = bus.wb_valid & bus.wb_wen;
    assign wb_wr   = wb_clr & wb_live;

    assign iss_idx  = bus.iss_rd[AW-1:0];
    assign iss_live = live(bus.iss_rd);

    // A reservation clears if the register is free now or
    // is being released by the retire in this same cycle.
    assign iss_ok = ~bus.flush
                  & (~bus.iss_wen
                   | ~iss_live
                   | ~pending[iss_idx]
                   | (wb_clr & (bus.wb_rd == bus.iss_rd)));

    assign iss_set = bus.iss_valid & iss_ok
                   & bus.iss_wen & iss_live;

    assign bus.iss_ready = iss_ok;

    // Read ports with optional same-cycle forwarding of retire data.
    always_comb begin
        logic [4:0] a;
        idx_t       ai;
        logic       ok;
        logic       hit;
        rd_data_c = '0;
        rd_busy_c = '0;
        a         = '0;
        ai        = '0;
        ok        = 1'b0;
        hit       = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            a   = bus.rd_addr[5*k +: 5];
            ai  = a[AW-1:0];
            ok  = live(a);
            hit = BYPASS && wb_wr && (bus.wb_rd == a);
            if (ok) begin
                rd_data_c[XLEN*k +: XLEN] = hit ? bus.wb_data : gpr[ai];
                rd_busy_c[k] = pending[ai] & ~hit;
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;

    // Next scoreboard: retire clears, issue sets (set wins), flush zeroes.
    always_comb begin
        pend_nxt = pending;
        if (wb_wr) begin
            pend_nxt[wb_idx] = 1'b0;
        end
        if (iss_set) begin
            pend_nxt[iss_idx] = 1'b1;
        end
        if (bus.flush) begin
            pend_nxt = '0;
        end
    end

    // Scoreboard and sticky retire-of-unreserved-register flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (wb_wr && !pending[wb_idx]) begin
                sb_err <= 1'b1;
            end
        end
    end

    // PC and instret only move when an instruction retires.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pc      <= RESET_PC;
            instret <= '0;
        end else if (bus.wb_valid) begin
            pc      <= bus.wb_pc_wen ? bus.wb_pc_wdata
                                     : pc + XLEN'(4);
            instret <= instret + 64'd1;
        end
    end

    // Register file write; x0 and out-of-range writes are dropped.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_wr) begin
            gpr[wb_idx] <= bus.wb_data;
        end
    end

    // Flattened register file view for difftest.
    always_comb begin
        dbg_gpr = '0;
        for (int i = 0; i < NREG; i++) begin
            dbg_gpr[XLEN*i +: XLEN] = gpr[i];
        end
    end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Bench for wb_regfile_sb: directed scenarios with literal
// expectations plus randomized traffic against a reference model.
module tb_wb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int NRD  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [XLEN-1:0]      pc;
    logic [63:0]          instret;
    logic [NREG-1:0]      pending;
    logic                 sb_err;
    logic [NREG*XLEN-1:0] dbg_gpr;

    int vecs = 0;
    int errs = 0;

    wb_regfile_sb_if #(.XLEN(XLEN), .NRD(NRD)) bus ();

    wb_regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD),
        .BYPASS(1'b1), .RESET_PC(32'h8000_0000)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus),
        .pc        (pc),
        .instret   (instret),
        .pending   (pending),
        .sb_err    (sb_err),
        .dbg_gpr   (dbg_gpr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_gpr [NREG];
    logic [15:0] m_pend;
    logic [31:0] m_pc;
    logic [63:0] m_ins;
    logic        m_err;

    function automatic bit real_reg(input logic [4:0] a);
        return a != 0 && a < NREG;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!real_reg(a)) return 32'd0;
        if (bus.wb_valid && bus.wb_wen && bus.wb_rd == a) return bus.wb_data;
        return m_gpr[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!real_reg(a)) return 1'b0;
        if (bus.wb_valid && bus.wb_wen && bus.wb_rd == a) return 1'b0;
        return m_pend[a[3:0]];
    endfunction

    function automatic logic exp_ready();
        if (bus.flush) return 1'b0;
        if (!bus.iss_wen || !real_reg(bus.iss_rd)) return 1'b1;
        if (!m_pend[bus.iss_rd[3:0]]) return 1'b1;
        return bus.wb_valid && bus.wb_wen && bus.wb_rd == bus.iss_rd;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_gpr[i] = 32'd0;
        m_pend = '0;
        m_pc   = 32'h8000_0000;
        m_ins  = 64'd0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] np;
        logic        rdy;
        rdy = exp_ready();
        np  = m_pend;
        if (bus.wb_valid) begin
            if (bus.wb_wen && real_reg(bus.wb_rd)) begin
                if (!m_pend[bus.wb_rd[3:0]]) m_err = 1'b1;
                m_gpr[bus.wb_rd[3:0]] = bus.wb_data;
                np[bus.wb_rd[3:0]] = 1'b0;
            end
            m_pc  = bus.wb_pc_wen ? bus.wb_pc_wdata : m_pc + 32'd4;
            m_ins = m_ins + 64'd1;
        end
        if (bus.iss_valid && rdy && bus.iss_wen && real_reg(bus.iss_rd))
            np[bus.iss_rd[3:0]] = 1'b1;
        if (bus.flush) np = '0;
        m_pend = np;
    endtask

    // Single compare process: check on the falling edge, then advance.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        chk("pc", 64'(pc), 64'(m_pc));
        chk("instret", instret, m_ins);
        chk("pending", 64'(pending), 64'(m_pend));
        chk("sb_err", 64'(sb_err), 64'(m_err));
        for (int i = 0; i < NREG; i++)
            chk("dbg_gpr", 64'(dbg_gpr[XLEN*i +: XLEN]), 64'(m_gpr[i]));
        for (int k = 0; k < NRD; k++) begin
            chk("rd_data", 64'(bus.rd_data[XLEN*k +: XLEN]),
                64'(exp_data(bus.rd_addr[5*k +: 5])));
            chk("rd_busy", 64'(bus.rd_busy[k]),
                64'(exp_busy(bus.rd_addr[5*k +: 5])));
        end
        chk("iss_ready", 64'(bus.iss_ready), 64'(exp_ready()));
        if (rst_n) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.rd_addr     = '0;
        bus.iss_valid   = 1'b0;
        bus.iss_wen     = 1'b0;
        bus.iss_rd      = '0;
        bus.flush       = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_wen      = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.wb_pc_wen   = 1'b0;
        bus.wb_pc_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_wen   = 1'b1;
        bus.iss_rd    = r;
    endtask

    task automatic retire(input logic [4:0] r, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_wen   = 1'b1;
        bus.wb_rd    = r;
        bus.wb_data  = d;
    endtask

    function automatic logic [4:0] pick_wb();
        int s;
        if ($urandom_range(0, 2) != 0 && m_pend != 0) begin
            s = $urandom_range(0, NREG - 1);
            for (int i = 0; i < NREG; i++)
                if (m_pend[(s + i) % NREG]) return 5'((s + i) % NREG);
        end
        return 5'($urandom_range(0, 19));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        bus.iss_wen = 1'b1;
        bus.iss_rd  = 5'd5;
        #1;
        chk("t1_pc", 64'(pc), 64'h8000_0000);
        chk("t1_instret", instret, 64'd0);
        chk("t1_pending", 64'(pending), 64'd0);
        chk("t1_gpr_zero", 64'(dbg_gpr != '0), 64'd0);
        chk("t1_iss_ready", 64'(bus.iss_ready), 64'd1);
        step();

        // Reserve, observe busy, bypass on retire
        issue(5'd5);
        step();
        idle();
        bus.rd_addr = {5'd0, 5'd5};
        #1;
        chk("t2_busy", 64'(bus.rd_busy[0]), 64'd1);
        step();
        retire(5'd5, 32'h1234);
        #1;
        chk("t2_bypass", 64'(bus.rd_data[31:0]), 64'h1234);
        chk("t2_busy_byp", 64'(bus.rd_busy[0]), 64'd0);
        step();
        idle();
        #1;
        chk("t2_gpr5", 64'(dbg_gpr[5*32 +: 32]), 64'h1234);
        chk("t2_pend5", 64'(pending[5]), 64'd0);
        chk("t2_pc", 64'(pc), 64'h8000_0004);
        chk("t2_instret", instret, 64'd1);

        // WAW stall, released by same-cycle retire, set wins
        issue(5'd7);
        step();
        issue(5'd7);
        #1;
        chk("t3_stall", 64'(bus.iss_ready), 64'd0);
        retire(5'd7, 32'h77);
        #1;
        chk("t3_release", 64'(bus.iss_ready), 64'd1);
        step();
        idle();
        #1;
        chk("t3_pend7", 64'(pending[7]), 64'd1);
        chk("t3_sb_err", 64'(sb_err), 64'd0);
        chk("t3_instret", instret, 64'd2);

        // x0 and out-of-range destinations
        retire(5'd0, 32'hFFFF_FFFF);
        bus.rd_addr = {5'd20, 5'd0};
        #1;
        chk("t4_x0_read", 64'(bus.rd_data[31:0]), 64'd0);
        step();
        idle();
        retire(5'd20, 32'hDEAD_BEEF);
        bus.rd_addr = {5'd20, 5'd0};
        #1;
        chk("t4_r20_read", 64'(bus.rd_data[63:32]), 64'd0);
        chk("t4_r20_busy", 64'(bus.rd_busy[1]), 64'd0);
        step();
        idle();
        #1;
        chk("t4_gpr0", 64'(dbg_gpr[31:0]), 64'd0);
        chk("t4_sb_err", 64'(sb_err), 64'd0);
        chk("t4_pending", 64'(pending), 64'h80);

        // Redirect, idle hold, sticky sb_err
        bus.wb_valid    = 1'b1;
        bus.wb_pc_wen   = 1'b1;
        bus.wb_pc_wdata = 32'h8000_0100;
        step();
        idle();
        #1;
        chk("t5_redirect", 64'(pc), 64'h8000_0100);
        step();
        step();
        step();
        #1;
        chk("t5_pc_hold", 64'(pc), 64'h8000_0100);
        chk("t5_ins_hold", instret, 64'd5);
        retire(5'd3, 32'h33);
        step();
        idle();
        #1;
        chk("t5_sb_err", 64'(sb_err), 64'd1);
        chk("t5_gpr3", 64'(dbg_gpr[3*32 +: 32]), 64'h33);
        step();
        step();
        #1;
        chk("t5_sticky", 64'(sb_err), 64'd1);

        // Flush beats issue, then async reset mid-retire
        issue(5'd3);
        step();
        issue(5'd5);
        step();
        idle();
        #1;
        chk("t6_pend", 64'(pending), 64'h00A8);
        issue(5'd9);
        bus.flush = 1'b1;
        #1;
        chk("t6_flush_rdy", 64'(bus.iss_ready), 64'd0);
        step();
        idle();
        #1;
        chk("t6_flushed", 64'(pending), 64'd0);
        chk("t6_pc", 64'(pc), 64'h8000_0104);
        retire(5'd4, 32'h44);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pc", 64'(pc), 64'h8000_0000);
        chk("t6_rst_ins", instret, 64'd0);
        chk("t6_rst_err", 64'(sb_err), 64'd0);
        chk("t6_rst_gpr", 64'(dbg_gpr != '0), 64'd0);
        idle();
        step();
        step();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            bus.iss_valid   = 1'($urandom_range(0, 1));
            bus.iss_wen     = ($urandom_range(0, 3) != 0);
            bus.iss_rd      = 5'($urandom_range(0, 19));
            bus.flush       = ($urandom_range(0, 19) == 0);
            bus.wb_valid    = 1'($urandom_range(0, 1));
            bus.wb_wen      = ($urandom_range(0, 3) != 0);
            bus.wb_rd       = pick_wb();
            bus.wb_data     = $urandom;
            bus.wb_pc_wen   = ($urandom_range(0, 7) == 0);
            bus.wb_pc_wdata = $urandom;
            for (int k = 0; k < NRD; k++)
                bus.rd_addr[5*k +: 5] = ($urandom_range(0, 1) != 0)
                    ? bus.wb_rd : 5'($urandom_range(0, 19));
            if (n == 1500) begin
                #2;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
